// File: rtl/moda_pipe_mul.sv
// moda_pipe_mul
// Three-stage pipelined unsigned W x W multiplier with optional per-transaction
// truncation of selected half-width sub-products (approximate mode).
//
// Parameters
//   W      operand width (even, 4..32)
//   TRUNC  number of low bits cleared in an approximated sub-product (0..W/2)
//   AMASK  quadrants subject to approximation: bit0 LL, bit1 LH, bit2 HL, bit3 HH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   pipeline can take an operand pair this cycle
//   a, b       unsigned operands
//   approx_en  approximate mode for this operand pair
//   out_valid  result present on prod/out_approx
//   out_ready  downstream takes the result this cycle
//   prod       2W-bit product
//   out_approx approx_en that travelled with the result on prod
//
// Stages: S1 holds operands and mode, S2 holds the four sub-products and mode,
// S3 holds the final sum (the output registers). The whole pipe moves as one
// when advance is high, so bubbles stay where they are and a stalled result
// freezes everything behind it.

module moda_pipe_mul #(
    parameter int         W     = 16,
    parameter int         TRUNC = 4,
    parameter logic [3:0] AMASK = 4'b0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            approx_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  prod,
    output logic            out_approx
);

    localparam int H = W / 2;

    // Low TRUNC bits cleared, all others kept; TRUNC=0 gives all ones.
    localparam logic [W-1:0] TRUNC_MASK = {W{1'b1}} << TRUNC;

    // Apply truncation to one sub-product when its quadrant is approximated.
    function automatic logic [W-1:0] approx_sub(input logic [W-1:0] p,
                                                input logic       trunc_en);
        logic [W-1:0] r;
        if (trunc_en) begin
            r = p & TRUNC_MASK;
        end else begin
            r = p;
        end
        return r;
    endfunction

    logic            advance_s;

    logic            s1_valid_r;
    logic [W-1:0]    s1_a_r;
    logic [W-1:0]    s1_b_r;
    logic            s1_apx_r;

    logic            s2_valid_r;
    logic [W-1:0]    s2_ll_r;
    logic [W-1:0]    s2_lh_r;
    logic [W-1:0]    s2_hl_r;
    logic [W-1:0]    s2_hh_r;
    logic            s2_apx_r;

    logic [W-1:0]    ll_s;
    logic [W-1:0]    lh_s;
    logic [W-1:0]    hl_s;
    logic [W-1:0]    hh_s;
    logic [W:0]      mid_s;
    logic [2*W-1:0]  prod_s;

    // The pipe moves whenever the output slot is empty or being drained.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Half-width sub-products of the S1 operands, truncated where selected.
    always_comb begin
        ll_s = W'(s1_a_r[H-1:0]) * W'(s1_b_r[H-1:0]);
        lh_s = W'(s1_a_r[H-1:0]) * W'(s1_b_r[W-1:H]);
        hl_s = W'(s1_a_r[W-1:H]) * W'(s1_b_r[H-1:0]);
        hh_s = W'(s1_a_r[W-1:H]) * W'(s1_b_r[W-1:H]);
        ll_s = approx_sub(ll_s, s1_apx_r && AMASK[0]);
        lh_s = approx_sub(lh_s, s1_apx_r && AMASK[1]);
        hl_s = approx_sub(hl_s, s1_apx_r && AMASK[2]);
        hh_s = approx_sub(hh_s, s1_apx_r && AMASK[3]);
    end

    // Recombine the S2 sub-products; the middle sum keeps its carry bit so
    // the 2W-bit result is exact.
    always_comb begin
        mid_s  = {1'b0, s2_lh_r} + {1'b0, s2_hl_r};
        prod_s = {s2_hh_r, {W{1'b0}}}
               + {{(H-1){1'b0}}, mid_s, {H{1'b0}}}
               + {{W{1'b0}}, s2_ll_r};
    end

    // Stage 1: capture operands and mode; valid follows the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_apx_r   <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_a_r     <= a;
            s1_b_r     <= b;
            s1_apx_r   <= approx_en;
        end
    end

    // Stage 2: capture the four (possibly truncated) sub-products and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_ll_r    <= {W{1'b0}};
            s2_lh_r    <= {W{1'b0}};
            s2_hl_r    <= {W{1'b0}};
            s2_hh_r    <= {W{1'b0}};
            s2_apx_r   <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_ll_r    <= ll_s;
            s2_lh_r    <= lh_s;
            s2_hl_r    <= hl_s;
            s2_hh_r    <= hh_s;
            s2_apx_r   <= s1_apx_r;
        end
    end

    // Stage 3: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            prod       <= {(2*W){1'b0}};
            out_approx <= 1'b0;
        end else if (advance_s) begin
            out_valid  <= s2_valid_r;
            prod       <= prod_s;
            out_approx <= s2_apx_r;
        end
    end

endmodule

// File: doc/moda_pipe_mul.md
MODA_PIPE_MUL -- requirements
Module: moda_pipe_mul

Interface
REQ-001 SHALL have parameter W, default 16; operand width, even, 4..32.
REQ-002 SHALL have parameter TRUNC, default 4; low bits zeroed in an approximated sub-product, 0..W/2.
REQ-003 SHALL have parameter AMASK, default 4'b0001; approximated quadrants: bit0 LL, bit1 LH, bit2 HL, bit3 HH.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  block accepts operand pair.
REQ-008 SHALL have port a  input  W  unsigned multiplicand.
REQ-009 SHALL have port b  input  W  unsigned multiplier.
REQ-010 SHALL have port approx_en  input  1  per-transaction approximate mode.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port prod  output  2W  product.
REQ-014 SHALL have port out_approx  output  1  approx_en of the transaction on prod.

Function
REQ-015 SHALL split operands: ah=a[W-1:W/2], al=a[W/2-1:0], bh/bl likewise.
REQ-016 SHALL form W-bit sub-products LL=al*bl, LH=al*bh, HL=ah*bl, HH=ah*bh.
REQ-017 SHALL, when the transaction's approx_en=1 and AMASK bit set, zero bits [TRUNC-1:0] of that sub-product; otherwise use the exact sub-product.
REQ-018 SHALL compute prod = (HH<<W) + ((LH+HL)<<(W/2)) + LL exactly, in 2W bits, with no overflow possible.
REQ-019 SHALL implement three register stages: S1 operands+mode, S2 four sub-products+mode, S3 prod+out_approx.
REQ-020 SHALL define advance = !out_valid || out_ready; all stages, valid bits included, load only when advance=1.
REQ-021 SHALL drive in_ready = advance (combinational); a transfer occurs when in_valid && in_ready.
REQ-022 SHALL give latency 3: pair accepted at edge k appears with out_valid=1 after edge k+2, absent stall.
REQ-023 SHALL sustain one result per cycle when out_ready stays 1.
REQ-024 SHALL, while out_valid=1 and out_ready=0, hold prod, out_approx, all stage contents stable, and keep in_ready=0.
REQ-025 SHALL propagate bubbles unchanged (no bubble collapsing); stage valid bit follows prior stage on each advance.
REQ-026 SHALL deliver results in acceptance order; no drop, no duplicate.
REQ-027 SHALL accept a new pair in the same cycle a result is consumed (out_ready=1, out_valid=1).
REQ-028 SHALL ignore a, b, approx_en when in_valid=0 or in_ready=0.
REQ-029 SHALL allow TRUNC=0, making approx_en a no-op (result always exact).

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear all stage valid bits, prod=0, out_approx=0, out_valid=0.
REQ-031 SHALL drive in_ready=1 during and after reset (advance true because out_valid=0).
REQ-032 SHALL discard in-flight transactions on reset mid-operation; no stale result after release.

Verification (W=16, TRUNC=4, AMASK=4'b0001)
REQ-033 exact: a=FFFF, b=FFFF, approx_en=0, out_ready=1 -> prod=FFFE0001, out_approx=0, third edge after accept.
REQ-034 approx LL: a=00FF, b=00FF, approx_en=1 -> prod=0000FE00 (exact 0000FE01), out_approx=1.
REQ-035 masked quadrant: a=FF00, b=FF00, approx_en=1 -> prod=FE010000 (HH not approximated).
REQ-036 backpressure: 4 pairs back-to-back, out_ready=0 for 5 cycles after first out_valid -> prod held, in_ready=0, all 4 results later in order.
REQ-037 throughput: 8 pairs consecutive, out_ready=1 -> 8 results on 8 consecutive cycles, first at latency 3.
REQ-038 reset mid-op: 2 pairs in flight, pulse rst_n low -> out_valid=0 immediately, no result until new pair accepted.
